// File: rtl/reloj_pkg.sv
// Shared definitions for the digital-clock blocks: field widths, field limits, alarm-set states.
// Latency: n/a (types, constants and one elaboration-time helper only).
// Backpressure: n/a.
package reloj_pkg;

  localparam int HORAS_W     = 5;
  localparam int MINUTOS_W   = 7;
  localparam int MAX_HORAS   = 23;
  localparam int MAX_MINUTOS = 59;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    EDIT_HORAS   = 2'd1,
    EDIT_MINUTOS = 2'd2
  } alarm_set_state_t;

  // Clamp an integer parameter into [lo, hi]; used at elaboration only.
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/wrap_counter_step.sv
// Combinational +1/-1 on a bounded field, wrapping MAX->0 on increment and 0->MAX on decrement.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; simultaneous inc and dec cancel and the value passes through.
module wrap_counter_step #(
  parameter int W   = 5,
  parameter int MAX = 23
) (
  input  logic [W-1:0] i_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val
);

  localparam logic [W-1:0] LMAX = W'(MAX);
  localparam logic [W-1:0] ONE  = W'(1);

  // Compare against the limit first, then step, so the result never leaves 0..MAX.
  always_comb begin
    o_val = i_val;
    if (i_inc && !i_dec) begin
      o_val = (i_val >= LMAX) ? '0 : i_val + ONE;
    end else if (i_dec && !i_inc) begin
      o_val = (i_val == '0) ? LMAX : i_val - ONE;
    end
  end

endmodule

// File: rtl/alarm_setter.sv
// Alarm-time programming: button edges edit shadow hour/minute, committed atomically on set; optional ALARM_AUTOREPEAT_EN.
// Latency: a button first sampled high at edge k takes effect at edge k; al_update is high the cycle after commit.
// Backpressure: none; coincident events resolve set > next > up/down, up+down cancel, inactivity timeout aborts.
module alarm_setter
  import reloj_pkg::*;
#(
  parameter int RESET_HORAS   = 6,
  parameter int RESET_MINUTOS = 0,
  parameter int TIMEOUT_TICKS = 30,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1hz,
  input  logic                 btn_set,
  input  logic                 btn_next,
  input  logic                 btn_up,
  input  logic                 btn_down,
  output logic [HORAS_W-1:0]   horasAl,
  output logic [MINUTOS_W-1:0] minutosAl,
  output logic [HORAS_W-1:0]   horas_edit,
  output logic [MINUTOS_W-1:0] minutos_edit,
  output logic                 set_mode,
  output logic                 sel_horas,
  output logic                 al_update
);

  // Parameters are clamped into legal ranges; an out-of-range value is still flagged.
  localparam int RH_C = clamp_int(RESET_HORAS, 0, MAX_HORAS);
  localparam int RM_C = clamp_int(RESET_MINUTOS, 0, MAX_MINUTOS);
  localparam int TO_C = clamp_int(TIMEOUT_TICKS, 1, 1 << 20);
  localparam int TO_W = $clog2(TO_C + 1);

  localparam logic [HORAS_W-1:0]   RH_V   = HORAS_W'(RH_C);
  localparam logic [MINUTOS_W-1:0] RM_V   = MINUTOS_W'(RM_C);
  localparam logic [TO_W-1:0]      TO_LST = TO_W'(TO_C - 1);
  localparam logic [TO_W-1:0]      TO_ONE = TO_W'(1);

  if (RH_C != RESET_HORAS) begin : g_bad_rh
    $error("alarm_setter: RESET_HORAS out of range, clamped");
  end
  if (RM_C != RESET_MINUTOS) begin : g_bad_rm
    $error("alarm_setter: RESET_MINUTOS out of range, clamped");
  end
  if (TO_C != TIMEOUT_TICKS) begin : g_bad_to
    $error("alarm_setter: TIMEOUT_TICKS out of range, clamped");
  end

  alarm_set_state_t r_state, w_state_nxt;

  logic r_prev_set, r_prev_next, r_prev_up, r_prev_down;
  logic [HORAS_W-1:0]   r_horas_al, r_horas_ed, w_horas_step;
  logic [MINUTOS_W-1:0] r_minutos_al, r_minutos_ed, w_minutos_step;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_al_update;

  logic w_ev_set, w_ev_next, w_ev_up, w_ev_down, w_ev_any;
  logic w_editing, w_sel_h, w_step_ok, w_inc, w_dec;
  logic w_load, w_commit, w_timeout, w_to_clr;
  logic w_rep_step, w_rep_up, w_rep_dn;

  // Rising-edge detection; prev flops reset high so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_set  <= 1'b1;
      r_prev_next <= 1'b1;
      r_prev_up   <= 1'b1;
      r_prev_down <= 1'b1;
    end else begin
      r_prev_set  <= btn_set;
      r_prev_next <= btn_next;
      r_prev_up   <= btn_up;
      r_prev_down <= btn_down;
    end
  end

  assign w_ev_set  = btn_set  & ~r_prev_set;
  assign w_ev_next = btn_next & ~r_prev_next;
  assign w_ev_up   = btn_up   & ~r_prev_up;
  assign w_ev_down = btn_down & ~r_prev_down;
  assign w_ev_any  = w_ev_set | w_ev_next | w_ev_up | w_ev_down;

  assign w_editing = (r_state != IDLE);
  assign w_sel_h   = (r_state == EDIT_HORAS);

`ifdef ALARM_AUTOREPEAT_EN
  logic [31:0] r_rep_cnt, w_rep_cnt_inc;
  logic        r_rep_act, w_hold;

  assign w_hold        = w_editing & (btn_up ^ btn_down);
  assign w_rep_cnt_inc = r_rep_cnt + 32'd1;
  assign w_rep_step    = w_hold & ~w_ev_any &
                         (r_rep_act ? (w_rep_cnt_inc == 32'(REPEAT_PERIOD))
                                    : (w_rep_cnt_inc == 32'(REPEAT_DELAY)));
  assign w_rep_up      = w_rep_step & btn_up;
  assign w_rep_dn      = w_rep_step & btn_down;

  // Repeat timer: first step after REPEAT_DELAY cycles of a lone held direction, then every REPEAT_PERIOD.
  always_ff @(posedge clk) begin
    if (rst || !w_hold || w_ev_any || w_timeout) begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b0;
    end else if (w_rep_step) begin
      r_rep_cnt <= '0;
      r_rep_act <= 1'b1;
    end else begin
      r_rep_cnt <= w_rep_cnt_inc;
    end
  end
`else
  assign w_rep_step = 1'b0;
  assign w_rep_up   = 1'b0;
  assign w_rep_dn   = 1'b0;
`endif

  // Up/down only act when no higher-priority set/next event is present in the same cycle.
  assign w_step_ok = w_editing & ~w_ev_set & ~w_ev_next;
  assign w_inc     = w_step_ok & ((w_ev_up & ~w_ev_down) | w_rep_up);
  assign w_dec     = w_step_ok & ((w_ev_down & ~w_ev_up) | w_rep_dn);

  wrap_counter_step #(.W(HORAS_W), .MAX(MAX_HORAS)) u_step_horas (
    .i_val (r_horas_ed),
    .i_inc (w_inc & w_sel_h),
    .i_dec (w_dec & w_sel_h),
    .o_val (w_horas_step)
  );

  wrap_counter_step #(.W(MINUTOS_W), .MAX(MAX_MINUTOS)) u_step_minutos (
    .i_val (r_minutos_ed),
    .i_inc (w_inc & ~w_sel_h),
    .i_dec (w_dec & ~w_sel_h),
    .o_val (w_minutos_step)
  );

  // Any event (even a suppressed one) or repeat step restarts the inactivity count.
  assign w_to_clr  = w_ev_any | w_rep_step;
  assign w_timeout = w_editing & ~w_to_clr & tick_1hz & (r_to_cnt == TO_LST);

  // Inactivity counter of tick_1hz pulses while editing.
  always_ff @(posedge clk) begin
    if (rst || !w_editing || w_to_clr || w_timeout) begin
      r_to_cnt <= '0;
    end else if (tick_1hz) begin
      r_to_cnt <= r_to_cnt + TO_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ev_set) begin
          w_load      = 1'b1;
          w_state_nxt = EDIT_HORAS;
        end
      end
      EDIT_HORAS, EDIT_MINUTOS: begin
        if (w_ev_set) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_ev_next) begin
          w_state_nxt = (r_state == EDIT_HORAS) ? EDIT_MINUTOS : EDIT_HORAS;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shadow and committed time registers; committed values move only on commit or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_horas_al   <= RH_V;
      r_minutos_al <= RM_V;
      r_horas_ed   <= RH_V;
      r_minutos_ed <= RM_V;
      r_al_update  <= 1'b0;
    end else begin
      r_al_update <= w_commit;
      if (w_commit) begin
        r_horas_al   <= r_horas_ed;
        r_minutos_al <= r_minutos_ed;
      end
      if (w_load) begin
        r_horas_ed   <= r_horas_al;
        r_minutos_ed <= r_minutos_al;
      end else if (w_step_ok) begin
        r_horas_ed   <= w_horas_step;
        r_minutos_ed <= w_minutos_step;
      end
    end
  end

  assign horasAl      = r_horas_al;
  assign minutosAl    = r_minutos_al;
  assign horas_edit   = r_horas_ed;
  assign minutos_edit = r_minutos_ed;
  assign set_mode     = w_editing;
  assign sel_horas    = w_sel_h;
  assign al_update    = r_al_update;

endmodule
